// File: rtl/uart_bus_bridge.sv
// UART-to-bus debug bridge: 8N1 read/write commands on rx become bus transactions; status and read data return on tx.
// Optional bus timeout abort is enabled by defining UART_BRIDGE_TIMEOUT_EN.
module uart_bus_bridge #(
  parameter int clks_per_bit = 434,
  parameter int bus_timeout  = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic        tx,
  output logic        bus_access,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_wr_val,
  output logic        bus_wr_en,
  output logic [3:0]  bus_bytesel,
  input  logic        bus_ack,
  input  logic        bus_error,
  input  logic [31:0] bus_data
);

  localparam int CW = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(clks_per_bit - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(clks_per_bit / 2 - 1);

  if (clks_per_bit < 4) begin : g_bad_clks_per_bit
    $error("clks_per_bit must be at least 4");
  end
  if (bus_timeout < 2) begin : g_bad_bus_timeout
    $error("bus_timeout must be at least 2");
  end

  // ---------------- RX engine ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  rx_state_t rx_state, rx_next;

  logic          rx_s1, rx_s2, rx_d;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_byte;
  logic          rx_tick, rx_strobe, rx_ferr;

  assign rx_tick   = (rx_cnt == BIT_LAST);
  assign rx_strobe = (rx_state == RX_STOP) && rx_tick && rx_s2;
  assign rx_ferr   = (rx_state == RX_STOP) && rx_tick && !rx_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_d     <= 1'b1;
      rx_state <= RX_IDLE;
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_d     <= rx_s2;
      rx_state <= rx_next;
    end
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_d && !rx_s2) rx_next = RX_START;
      RX_START: if (rx_cnt == HALF_LAST) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt  <= '0;
      rx_bit  <= '0;
      rx_byte <= '0;
    end else begin
      if (rx_state == RX_IDLE || rx_state != rx_next || rx_tick) rx_cnt <= '0;
      else rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == RX_START) rx_bit <= '0;
      if (rx_state == RX_DATA && rx_tick) begin
        rx_bit  <= rx_bit + 1'b1;
        rx_byte <= {rx_s2, rx_byte[7:1]};
      end
    end
  end

  // ---------------- command FSM ----------------
  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_BUS, ST_RESP} st_t;
  st_t state, state_next;

  logic          is_wr;
  logic [1:0]    byte_cnt;
  logic [23:0]   addr_hi;
  logic [39:0]   resp_buf;
  logic [2:0]    resp_left;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [9:0]    tx_frame;
  logic          tx_tick;
  logic          timeout_hit;

  assign bus_access  = (state == ST_BUS);
  assign bus_wr_en   = bus_access && is_wr;
  assign bus_bytesel = {4{bus_access}};
  assign tx_frame    = {1'b1, resp_buf[39:32], 1'b0};
  assign tx_tick     = (tx_cnt == BIT_LAST);

`ifdef UART_BRIDGE_TIMEOUT_EN
  localparam int TW = (bus_timeout > 1) ? $clog2(bus_timeout) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(bus_timeout - 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                to_cnt <= '0;
    else if (state == ST_BUS)  to_cnt <= to_cnt + 1'b1;
    else                       to_cnt <= '0;
  end
  assign timeout_hit = (state == ST_BUS) && (to_cnt == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:
        if (rx_strobe)
          state_next = (rx_byte == 8'h01 || rx_byte == 8'h02) ? ST_ADDR : ST_RESP;
      ST_ADDR:
        if (rx_ferr) state_next = ST_IDLE;
        else if (rx_strobe && byte_cnt == 2'd3) state_next = is_wr ? ST_DATA : ST_BUS;
      ST_DATA:
        if (rx_ferr) state_next = ST_IDLE;
        else if (rx_strobe && byte_cnt == 2'd3) state_next = ST_BUS;
      ST_BUS:
        if (bus_ack || bus_error || timeout_hit) state_next = ST_RESP;
      ST_RESP:
        if (tx_tick && tx_bit == 4'd9 && resp_left == 3'd1) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_wr      <= 1'b0;
      byte_cnt   <= '0;
      addr_hi    <= '0;
      bus_addr   <= '0;
      bus_wr_val <= '0;
      resp_buf   <= '0;
      resp_left  <= '0;
      tx_cnt     <= '0;
      tx_bit     <= '0;
      tx         <= 1'b1;
    end else begin
      tx <= 1'b1;
      case (state)
        ST_IDLE: begin
          byte_cnt <= '0;
          tx_cnt   <= '0;
          tx_bit   <= '0;
          if (rx_strobe) begin
            is_wr     <= (rx_byte == 8'h02);
            resp_buf  <= {8'hFF, 32'h0};
            resp_left <= 3'd1;
          end
        end
        ST_ADDR:
          if (rx_strobe) begin
            byte_cnt <= byte_cnt + 1'b1;
            // Only the word address is kept, so the last byte drops its two LSBs.
            if (byte_cnt == 2'd3) bus_addr <= {addr_hi, rx_byte[7:2]};
            else                  addr_hi  <= {addr_hi[15:0], rx_byte};
          end
        ST_DATA:
          if (rx_strobe) begin
            byte_cnt   <= byte_cnt + 1'b1;
            bus_wr_val <= {bus_wr_val[23:0], rx_byte};
          end
        ST_BUS: begin
          if (bus_ack || bus_error) begin
            resp_buf  <= {(bus_error ? 8'h01 : 8'h00), ((is_wr || bus_error) ? 32'h0 : bus_data)};
            resp_left <= is_wr ? 3'd1 : 3'd5;
          end else if (timeout_hit) begin
            resp_buf  <= {8'h02, 32'h0};
            resp_left <= is_wr ? 3'd1 : 3'd5;
          end
        end
        ST_RESP: begin
          tx <= tx_frame[tx_bit];
          if (tx_tick) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
              tx_bit    <= '0;
              resp_buf  <= {resp_buf[31:0], 8'h00};
              resp_left <= resp_left - 1'b1;
            end else begin
              tx_bit <= tx_bit + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/uart_bus_bridge.md
Name: uart_bus_bridge

Overview:
- Synthesizable debug bridge: 8N1 serial command stream on rx, bus transactions as a bus initiator, responses serialized back on tx.
- Drives the same word-addressed bus the on-chip slaves respond to (bus_access/bus_cs/bus_ack style), so a host PC can peek/poke memory and peripherals.
- Sits between the board UART pins and a bus arbiter master port.

Parameters:
- clks_per_bit, 434, clk cycles per serial bit (50 MHz / 115200); must be >= 4.
- bus_timeout, 1024, cycles to wait for bus_ack/bus_error before aborting (only with the optional feature).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- rx  in  1  serial input, idle high, asynchronous to clk.
- tx  out  1  serial output, idle high.
- bus_access  out  1  transaction request, held until ack/error.
- bus_addr  out  30  word address (command byte address [31:2]).
- bus_wr_val  out  32  write data.
- bus_wr_en  out  1  1 = write, 0 = read; valid while bus_access.
- bus_bytesel  out  4  byte enables; always 4'b1111 during an access.
- bus_ack  in  1  transaction complete.
- bus_error  in  1  transaction failed; treated as completion.
- bus_data  in  32  read data, sampled in the ack cycle.

Behaviour:
- Reset (async assert, sync release): tx=1, bus_access=0, bus_wr_en=0, bus_addr=0, bus_wr_val=0, bus_bytesel=0; FSM to IDLE; RX/TX engines idle.
- RX engine:
  - rx passes a 2-flop synchronizer.
  - A falling edge starts the bit counter. The start bit is re-checked at clks_per_bit/2; if high, it is a glitch and is ignored.
  - 8 data bits are sampled LSB first, each one clks_per_bit after the previous sample.
  - The stop bit is sampled next. Stop=1 emits a 1-cycle byte strobe. Stop=0 is a framing error: the byte is discarded and the command FSM returns to IDLE.
- Command format (all multi-byte fields MSB first):
  - Read: 0x01, A3, A2, A1, A0.
  - Write: 0x02, A3..A0, D3..D0.
- Command FSM states: IDLE -> ADDR (4 bytes) -> [DATA (4 bytes) if write] -> BUS -> RESP -> IDLE.
  - Any other opcode in IDLE: queue response 0xFF, go to RESP.
  - Address bits [1:0] are ignored.
- BUS state:
  - bus_access=1 from the cycle after the last command byte until the first cycle in which bus_ack or bus_error is sampled high.
  - bus_access drops on the following edge, so the earliest completion is a 1-cycle ack.
  - On ack, bus_data is captured for reads.
  - ack and error together count as error.
  - Status codes: 0x00 ok, 0x01 bus_error, 0x02 timeout.
- RESP state:
  - Read response: status byte, then D3..D0. On error or timeout the data bytes are 0x00.
  - Write response: status byte only.
  - Bytes are sent back-to-back: start bit 0, 8 data bits LSB first, stop bit 1, each bit clks_per_bit cycles. Stop-to-next-start gap is 0 cycles.
- RX bytes arriving during BUS or RESP are discarded; no buffering.
- tx returns to 1 after the final stop bit, then the FSM re-enters IDLE.
- Reset mid-frame: tx goes to 1 immediately and bus_access to 0; a partial command is lost.

Optional Feature:
- Macro: UART_BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter runs in BUS.
  - After bus_timeout cycles without ack/error, bus_access drops and status 0x02 is returned.
  - A late ack arriving after the abort is ignored.
- Undefined: no counter; the bridge waits indefinitely in BUS, and status 0x02 is never produced.

Test Plan (clks_per_bit=8):
- Read: rx 01 00 00 10 04, slave acks 1 cycle after bus_access with bus_data=0xDEADBEEF -> bus_addr=0x0000_0401, bus_wr_en=0, bytesel=F; tx bytes 00 DE AD BE EF, each frame 80 cycles.
- Write: rx 02 80 00 00 00 12 34 56 78 -> one access, bus_addr=0x2000_0000, bus_wr_en=1, bus_wr_val=0x12345678, bus_access high exactly until ack; tx 00.
- Error: read with bus_error=1 on completion -> tx 01 00 00 00 00.
- Bad opcode/framing: rx 0x55 -> tx FF. Byte with stop=0 inside ADDR -> no bus access; a following valid read completes normally.
- Timeout (macro on, bus_timeout=16): read, no ack -> bus_access high 16 cycles, tx 02 00 00 00 00. Macro off: bus_access stays high and tx stays idle.
- Reset: rst_n low during tx bit 3 -> tx=1 and bus_access=0 within the same cycle (async); the next command works.
